if_fetch_stage: RTL and testbench



---
 rtl/if_fetch_stage_if.sv | 77 +++++++
 rtl/if_fetch_stage.sv | 194 +++++++++++++++++++
 tb/tb_if_fetch_stage.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage_if
// Description : Bundle of every non-clock signal of the instruction-fetch
//               front end: the BTB lookup pair, the instruction-memory
//               request/response port, the redirect input and the
//               fetch-queue head presented to decode.
//               master : fetch-stage side (drives PC, requests, queue head)
//               slave  : environment side (BTB, memory, branch unit, decode)
// Revision    : 1.0 - initial release
// ============================================================================
interface if_fetch_stage_if #(
    parameter int XLEN = 32
);
    // BTB lookup
    logic [XLEN-1:0] if_PC;
    logic            btb_taken;
    logic [XLEN-1:0] btb_target_PC;

    // Instruction-memory request / response
    logic            proc2Imem_valid;
    logic [XLEN-1:0] proc2Imem_addr;
    logic            Imem2proc_ready;
    logic            Imem2proc_data_valid;
    logic [31:0]     Imem2proc_data;

    // Mispredict / recovery redirect
    logic            redirect_en;
    logic [XLEN-1:0] redirect_PC;

    // Fetch-queue head toward decode
    logic            fq_valid;
    logic [31:0]     fq_inst;
    logic [XLEN-1:0] fq_PC;
    logic [XLEN-1:0] fq_NPC;
    logic            fq_pred_taken;
    logic            decode_ready;

    modport master (
        output if_PC,
        input  btb_taken,
        input  btb_target_PC,
        output proc2Imem_valid,
        output proc2Imem_addr,
        input  Imem2proc_ready,
        input  Imem2proc_data_valid,
        input  Imem2proc_data,
        input  redirect_en,
        input  redirect_PC,
        output fq_valid,
        output fq_inst,
        output fq_PC,
        output fq_NPC,
        output fq_pred_taken,
        input  decode_ready
    );

    modport slave (
        input  if_PC,
        output btb_taken,
        output btb_target_PC,
        input  proc2Imem_valid,
        input  proc2Imem_addr,
        output Imem2proc_ready,
        output Imem2proc_data_valid,
        output Imem2proc_data,
        output redirect_en,
        output redirect_PC,
        input  fq_valid,
        input  fq_inst,
        input  fq_PC,
        input  fq_NPC,
        input  fq_pred_taken,
        output decode_ready
    );
endinterface
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage
// Description : Instruction-fetch front end. Owns the fetch PC, issues one
//               instruction-memory request per cycle while credit remains,
//               remembers the PC/prediction of every live in-flight request
//               in a tag FIFO, pairs in-order responses with their tags into
//               a fetch queue for decode, and on a redirect flushes queued
//               work and counts stale in-flight responses to discard.
// Ports       : clock - rising-edge clock
//               reset - asynchronous active-low reset
//               bus   - if_fetch_stage_if.master (BTB, Imem, redirect, decode)
// Parameters  : XLEN     - address width
//               FQ_DEPTH - queue depth and cap on queued + in-flight work
//                          (power of two, >= 2)
//               RESET_PC - fetch PC after reset
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_stage #(
    parameter int              XLEN     = 32,
    parameter int              FQ_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  wire logic           clock,
    input  wire logic           reset,
    if_fetch_stage_if.master    bus
);

    localparam int PW = $clog2(FQ_DEPTH);   // pointer width
    localparam int CW = PW + 1;             // count width (holds FQ_DEPTH)
    localparam logic [CW:0]   c_DEPTH_SUM = (CW+1)'(FQ_DEPTH);
    localparam logic [CW-1:0] c_DEPTH_CNT = CW'(FQ_DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0] r_pc;

    // Tag FIFO: prediction context of live in-flight requests
    logic [XLEN-1:0] r_tag_pc    [FQ_DEPTH];
    logic [XLEN-1:0] r_tag_npc   [FQ_DEPTH];
    logic            r_tag_taken [FQ_DEPTH];
    logic [PW-1:0]   r_tag_wr;
    logic [PW-1:0]   r_tag_rd;
    logic [CW-1:0]   r_live_cnt;

    // Responses still owed by memory for requests killed by a redirect
    logic [CW-1:0]   r_drop_cnt;

    // Fetch queue toward decode
    logic [31:0]     r_fq_inst   [FQ_DEPTH];
    logic [XLEN-1:0] r_fq_pc     [FQ_DEPTH];
    logic [XLEN-1:0] r_fq_npc    [FQ_DEPTH];
    logic            r_fq_taken  [FQ_DEPTH];
    logic [PW-1:0]   r_fq_head;
    logic [PW-1:0]   r_fq_tail;
    logic [CW-1:0]   r_fq_count;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    logic [CW:0] w_used;
    logic        w_req_valid;
    logic        w_accept;
    logic        w_resp;
    logic        w_resp_drop;
    logic        w_enq;
    logic        w_deq;
    logic        w_redirect;

    assign w_redirect  = bus.redirect_en;

    // Every queued entry, live request and stale request holds one credit,
    // so a response always finds room in the fetch queue.
    assign w_used      = {1'b0, r_fq_count} + {1'b0, r_live_cnt} + {1'b0, r_drop_cnt};
    assign w_req_valid = (w_used < c_DEPTH_SUM) && !w_redirect;
    assign w_accept    = w_req_valid && bus.Imem2proc_ready;

    assign w_resp      = bus.Imem2proc_data_valid;
    assign w_resp_drop = w_resp && (r_drop_cnt != '0);
    // A response during a redirect belongs to a request being killed.
    assign w_enq       = w_resp && (r_drop_cnt == '0) && !w_redirect;
    assign w_deq       = (r_fq_count != '0) && bus.decode_ready && !w_redirect;

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.if_PC           = r_pc;
    assign bus.proc2Imem_valid = w_req_valid;
    assign bus.proc2Imem_addr  = r_pc;

    assign bus.fq_valid        = (r_fq_count != '0);
    assign bus.fq_inst         = r_fq_inst[r_fq_head];
    assign bus.fq_PC           = r_fq_pc[r_fq_head];
    assign bus.fq_NPC          = r_fq_npc[r_fq_head];
    assign bus.fq_pred_taken   = r_fq_taken[r_fq_head];

    // ------------------------------------------------------------------
    // Fetch PC
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else if (w_redirect) begin
            r_pc <= bus.redirect_PC;
        end else if (w_accept) begin
            r_pc <= bus.btb_target_PC;
        end
    end

    // ------------------------------------------------------------------
    // Tag FIFO and in-flight accounting
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                r_tag_pc[i]    <= '0;
                r_tag_npc[i]   <= '0;
                r_tag_taken[i] <= 1'b0;
            end
            r_tag_wr   <= '0;
            r_tag_rd   <= '0;
            r_live_cnt <= '0;
            r_drop_cnt <= '0;
        end else if (w_redirect) begin
            // Everything live becomes stale; a response arriving now is
            // already one of those and is retired immediately.
            r_tag_wr   <= '0;
            r_tag_rd   <= '0;
            r_live_cnt <= '0;
            r_drop_cnt <= r_drop_cnt + r_live_cnt - CW'(w_resp);
        end else begin
            if (w_accept) begin
                r_tag_pc[r_tag_wr]    <= r_pc;
                r_tag_npc[r_tag_wr]   <= bus.btb_target_PC;
                r_tag_taken[r_tag_wr] <= bus.btb_taken;
                r_tag_wr              <= r_tag_wr + PW'(1);
            end
            if (w_enq) begin
                r_tag_rd <= r_tag_rd + PW'(1);
            end
            r_live_cnt <= r_live_cnt + CW'(w_accept) - CW'(w_enq);
            r_drop_cnt <= r_drop_cnt - CW'(w_resp_drop);
        end
    end

    // ------------------------------------------------------------------
    // Fetch queue
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FQ_DEPTH; i++) begin
                r_fq_inst[i]  <= '0;
                r_fq_pc[i]    <= '0;
                r_fq_npc[i]   <= '0;
                r_fq_taken[i] <= 1'b0;
            end
            r_fq_head  <= '0;
            r_fq_tail  <= '0;
            r_fq_count <= '0;
        end else if (w_redirect) begin
            r_fq_head  <= '0;
            r_fq_tail  <= '0;
            r_fq_count <= '0;
        end else begin
            if (w_enq) begin
                r_fq_inst[r_fq_tail]  <= bus.Imem2proc_data;
                r_fq_pc[r_fq_tail]    <= r_tag_pc[r_tag_rd];
                r_fq_npc[r_fq_tail]   <= r_tag_npc[r_tag_rd];
                r_fq_taken[r_fq_tail] <= r_tag_taken[r_tag_rd];
                r_fq_tail             <= r_fq_tail + PW'(1);
            end
            if (w_deq) begin
                r_fq_head <= r_fq_head + PW'(1);
            end
            r_fq_count <= r_fq_count + CW'(w_enq) - CW'(w_deq);
        end
    end

    // ------------------------------------------------------------------
    // Protocol checks
    // ------------------------------------------------------------------
    a_no_fq_overflow : assert property (
        @(posedge clock) disable iff (!reset)
        !(w_enq && (r_fq_count == c_DEPTH_CNT))
    );

    a_no_orphan_response : assert property (
        @(posedge clock) disable iff (!reset)
        !(w_resp && (r_live_cnt == '0) && (r_drop_cnt == '0))
    );

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_stage
// Description : Self-checking bench for if_fetch_stage. Models the BTB and an
//               in-order instruction memory with configurable latency, and
//               predicts every cycle's outputs from a queue-level model of
//               outstanding requests and the decode queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] C_RST_PC = 32'h100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    if_fetch_stage_if #(.XLEN(XLEN)) bus ();

    if_fetch_stage #(
        .XLEN     (XLEN),
        .FQ_DEPTH (DEPTH),
        .RESET_PC (C_RST_PC)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus.master)
    );

    // Single-entry BTB; misses predict fall-through
    logic [31:0] btb_pc  = 32'hFFFF_FFF0;
    logic [31:0] btb_tgt = 32'h0;
    always_comb begin
        bus.btb_taken     = (bus.if_PC == btb_pc);
        bus.btb_target_PC = (bus.if_PC == btb_pc) ? btb_tgt : bus.if_PC + 32'd4;
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic        tk;
        bit          stale;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] npc;
        logic        tk;
    } fqe_t;

    req_t        outq[$];
    fqe_t        mq[$];
    logic [31:0] ref_pc;
    int          cyc, lat;
    int          checks, errors;
    int          dut_acc;
    bit          seen_hit;

    // Stimulus for the next cycle
    logic        s_ready, s_redir, s_dec;
    logic [31:0] s_rpc;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        outq.delete();
        mq.delete();
        ref_pc = C_RST_PC;
    endtask

    // One clock cycle: drive at negedge, check, advance the model for the edge
    task automatic cycle();
        bit          resp, exp_valid, tk;
        logic [31:0] tgt;
        req_t        r;
        @(negedge clk);
        cyc++;
        resp = (outq.size() > 0) && (outq[0].due <= cyc);
        bus.Imem2proc_ready      = s_ready;
        bus.redirect_en          = s_redir;
        bus.redirect_PC          = s_rpc;
        bus.decode_ready         = s_dec;
        bus.Imem2proc_data_valid = resp;
        bus.Imem2proc_data       = resp ? inst_of(outq[0].pc) : 32'h0;
        #1;
        exp_valid = ((mq.size() + outq.size()) < DEPTH) && !s_redir;
        check("req_valid", {31'b0, bus.proc2Imem_valid}, {31'b0, exp_valid});
        check("if_pc", bus.if_PC, ref_pc);
        check("req_addr", bus.proc2Imem_addr, ref_pc);
        check("fq_valid", {31'b0, bus.fq_valid}, {31'b0, mq.size() > 0});
        if (mq.size() > 0) begin
            check("fq_inst", bus.fq_inst, mq[0].inst);
            check("fq_pc", bus.fq_PC, mq[0].pc);
            check("fq_npc", bus.fq_NPC, mq[0].npc);
            check("fq_taken", {31'b0, bus.fq_pred_taken}, {31'b0, mq[0].tk});
        end
        if (bus.fq_valid && bus.fq_PC == btb_pc && bus.fq_NPC == btb_tgt && bus.fq_pred_taken)
            seen_hit = 1'b1;
        if (bus.proc2Imem_valid && s_ready) dut_acc++;

        tk  = (ref_pc == btb_pc);
        tgt = tk ? btb_tgt : ref_pc + 32'd4;
        if (mq.size() > 0 && s_dec && !s_redir) void'(mq.pop_front());
        if (resp) begin
            r = outq.pop_front();
            if (!s_redir && !r.stale)
                mq.push_back('{inst_of(r.pc), r.pc, r.npc, r.tk});
        end
        if (s_redir) begin
            mq.delete();
            foreach (outq[i]) outq[i].stale = 1'b1;
            ref_pc = s_rpc;
        end else if (exp_valid && s_ready) begin
            outq.push_back('{ref_pc, tgt, tk, 1'b0, cyc + lat});
            ref_pc = tgt;
        end
    endtask

    task automatic quiet_inputs();
        bus.Imem2proc_ready      = 1'b0;
        bus.redirect_en          = 1'b0;
        bus.redirect_PC          = 32'h0;
        bus.decode_ready         = 1'b0;
        bus.Imem2proc_data_valid = 1'b0;
        bus.Imem2proc_data       = 32'h0;
    endtask

    // Reset asserted mid-cycle, checked immediately and after a clock edge
    task automatic do_reset();
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_if_pc", bus.if_PC, C_RST_PC);
        check("rst_fq_valid", {31'b0, bus.fq_valid}, 32'h0);
        quiet_inputs();
        @(posedge clk);
        #1;
        check("rst_hold_pc", bus.if_PC, C_RST_PC);
        check("rst_hold_valid", {31'b0, bus.fq_valid}, 32'h0);
        check("rst_fq_inst", bus.fq_inst, 32'h0);
        check("rst_fq_pc", bus.fq_PC, 32'h0);
        check("rst_fq_npc", bus.fq_NPC, 32'h0);
        check("rst_fq_taken", {31'b0, bus.fq_pred_taken}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; lat = 1; dut_acc = 0; seen_hit = 1'b0;
        s_ready = 1'b1; s_redir = 1'b0; s_dec = 1'b1; s_rpc = 32'h0;
        quiet_inputs();
        model_clear();

        // Streaming with a BTB hit at 0x108 -> 0x200
        btb_pc = 32'h108; btb_tgt = 32'h200;
        do_reset();
        lat = 1; s_ready = 1'b1; s_dec = 1'b1; s_redir = 1'b0;
        run(12);
        check("btb_hit_seen", {31'b0, seen_hit}, 32'h1);

        // Decode stalled: credit limits to DEPTH requests, then drain
        btb_pc = 32'hFFFF_FFF0;
        do_reset();
        s_dec = 1'b0; dut_acc = 0;
        run(8);
        check("stall_accepts", dut_acc, 32'd4);
        check("stall_pc", bus.if_PC, 32'h110);
        s_dec = 1'b1;
        run(10);

        // Slow memory, redirect with two requests in flight
        do_reset();
        lat = 3;
        run(2);
        s_redir = 1'b1; s_rpc = 32'h400;
        cycle();
        s_redir = 1'b0;
        begin
            int n = 0;
            while (!bus.fq_valid && n < 20) begin cycle(); n++; end
            check("redir_first_pc", bus.fq_PC, 32'h400);
        end
        run(8);

        // Redirect together with a response and a dequeue
        do_reset();
        lat = 1;
        run(6);
        s_redir = 1'b1; s_rpc = 32'h180;
        cycle();
        s_redir = 1'b0;
        run(8);

        // Reset mid-stream with three entries queued
        do_reset();
        s_dec = 1'b0;
        run(4);
        check("pre_rst_valid", {31'b0, bus.fq_valid}, 32'h1);
        do_reset();
        s_dec = 1'b1;
        run(4);

        // Randomized traffic
        btb_pc = 32'h120; btb_tgt = 32'h1C0;
        for (int i = 0; i < 600; i++) begin
            s_ready = ($urandom_range(0, 3) != 0);
            s_dec   = ($urandom_range(0, 2) != 0);
            s_redir = ($urandom_range(0, 19) == 0);
            s_rpc   = 32'h100 + (32'($urandom_range(0, 63)) << 2);
            lat     = $urandom_range(1, 4);
            cycle();
        end
        s_redir = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
